// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy obstacle engine: game state encoding,
// LFSR constants and the default coordinate width.
package flappy_pkg;

    localparam int          COORD_W_DEF = 11;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    // Fibonacci taps 16/14/13/11 as a bit mask over lfsr[15:0]
    localparam logic [15:0] LFSR_TAPS   = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DEAD = 2'b10
    } game_state_t;

endpackage

// File: rtl/flappy_pipe_channel.sv
// One scrolling pipe pair: position/gap state, move with wrap, reload,
// per-pixel hit and the "trailing edge crossed the bird this move" flag.
module flappy_pipe_channel
    import flappy_pkg::*;
#(
    parameter int IDX        = 0,
    parameter int COORD_W    = COORD_W_DEF,
    parameter int NUM_PIPES  = 4,
    parameter int PIPE_WIDTH = 80,
    parameter int GAP_HEIGHT = 100,
    parameter int GAP_MIN    = 40,
    parameter int SPACING    = 200,
    parameter int INIT_X     = 320,
    parameter int BIRD_X     = 100
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               reload,
    input  logic               move,
    input  logic [COORD_W-1:0] speed,
    input  logic [7:0]         rnd,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    output logic               hit,
    output logic               crossed
);

    localparam int CW = COORD_W + 1;
    localparam logic [COORD_W-1:0] X0   = COORD_W'(INIT_X + IDX * SPACING);
    localparam logic [COORD_W-1:0] G0   = COORD_W'(GAP_MIN + 32 * IDX);
    localparam logic [COORD_W-1:0] SPAN = COORD_W'(NUM_PIPES * SPACING);
    localparam logic [CW-1:0]      PW   = CW'(PIPE_WIDTH);
    localparam logic [CW-1:0]      GH   = CW'(GAP_HEIGHT);
    localparam logic [CW-1:0]      BX   = CW'(BIRD_X);

    logic [COORD_W-1:0] x, gap_top, x_next, gap_next;

    // A pipe that would pass x=0 re-enters one full ring span to the right
    always_comb begin
        x_next   = x - speed;
        gap_next = gap_top;
        if (x < speed) begin
            x_next   = x + SPAN - speed;
            gap_next = COORD_W'(GAP_MIN) + COORD_W'(rnd);
        end
    end

    always_comb begin
        hit = ({1'b0, pix_x} >= {1'b0, x}) && ({1'b0, pix_x} < {1'b0, x} + PW) &&
              (({1'b0, pix_y} < {1'b0, gap_top}) || ({1'b0, pix_y} >= {1'b0, gap_top} + GH));
        crossed = ({1'b0, x} + PW >= BX) && ({1'b0, x_next} + PW < BX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x       <= X0;
            gap_top <= G0;
        end else if (reload) begin
            x       <= X0;
            gap_top <= G0;
        end else if (move) begin
            x       <= x_next;
            gap_top <= gap_next;
        end
    end

endmodule

// File: rtl/flappy_obstacle_engine.sv
// N scrolling pipe pairs with pixel masks, collision, score and game FSM.
// Optional speed ramp on every 8th point: define FLAPPY_SPEEDUP_EN.
module flappy_obstacle_engine
    import flappy_pkg::*;
#(
    parameter int NUM_PIPES  = 4,
    parameter int COORD_W    = COORD_W_DEF,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int PIPE_WIDTH = 80,
    parameter int GAP_HEIGHT = 100,
    parameter int GAP_MIN    = 40,
    parameter int SPACING    = 200,
    parameter int INIT_X     = 320,
    parameter int SPEED      = 5,
    parameter int MAX_SPEED  = 12,
    parameter int BIRD_X     = 100,
    parameter int BIRD_SIZE  = 20
) (
    input  logic               iVGA_CLK,
    input  logic               iRST_n,
    input  logic               iStart,
    input  logic               iFrame,
    input  logic [COORD_W-1:0] iPix_x,
    input  logic [COORD_W-1:0] iPix_y,
    input  logic [COORD_W-1:0] iBird_y,
    output logic               oPipe_pix,
    output logic               oBird_pix,
    output logic [1:0]         oState,
    output logic [15:0]        oScore
);

    localparam int CW = COORD_W + 1;

    if (NUM_PIPES < 1 || NUM_PIPES > 8 ||
        NUM_PIPES * SPACING < H_RES + PIPE_WIDTH ||
        GAP_MIN + 255 + GAP_HEIGHT > V_RES) begin : g_param_err
        $error("flappy_obstacle_engine: illegal parameter combination");
    end

    game_state_t        state_q;
    logic [15:0]        lfsr;
    logic [COORD_W-1:0] speed;
    logic [NUM_PIPES-1:0] hit_v, crossed_v;
    logic               bird_hit, collide, ground, dying, move, reload, enter_run;
    logic [3:0]         cross_cnt;
    logic [16:0]        score_sum;
    logic [15:0]        score_next;

    always_comb begin
        bird_hit = ({1'b0, iPix_x} >= CW'(BIRD_X)) && ({1'b0, iPix_x} < CW'(BIRD_X + BIRD_SIZE)) &&
                   ({1'b0, iPix_y} >= {1'b0, iBird_y}) &&
                   ({1'b0, iPix_y} < {1'b0, iBird_y} + CW'(BIRD_SIZE));
        collide   = (state_q == ST_RUN) && oPipe_pix && oBird_pix;
        ground    = (state_q == ST_RUN) && iFrame && ({1'b0, iBird_y} >= CW'(V_RES - BIRD_SIZE));
        dying     = collide || ground;
        // Death takes priority over a coincident frame tick: nothing moves
        move      = (state_q == ST_RUN) && iFrame && !dying;
        reload    = (state_q == ST_DEAD) && iStart;
        enter_run = (state_q == ST_IDLE) && iStart;
        cross_cnt = '0;
        for (int i = 0; i < NUM_PIPES; i++) cross_cnt = cross_cnt + {3'b0, crossed_v[i]};
        score_sum  = {1'b0, oScore} + 17'(cross_cnt);
        score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end

    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
        flappy_pipe_channel #(
            .IDX(i), .COORD_W(COORD_W), .NUM_PIPES(NUM_PIPES), .PIPE_WIDTH(PIPE_WIDTH),
            .GAP_HEIGHT(GAP_HEIGHT), .GAP_MIN(GAP_MIN), .SPACING(SPACING),
            .INIT_X(INIT_X), .BIRD_X(BIRD_X)
        ) u_chan (
            .clk(iVGA_CLK), .rst_n(iRST_n), .reload(reload), .move(move),
            .speed(speed), .rnd(lfsr[7:0]), .pix_x(iPix_x), .pix_y(iPix_y),
            .hit(hit_v[i]), .crossed(crossed_v[i])
        );
    end

`ifdef FLAPPY_SPEEDUP_EN
    logic [COORD_W-1:0] speed_q;
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n)
            speed_q <= COORD_W'(SPEED);
        else if (enter_run)
            speed_q <= COORD_W'(SPEED);
        else if (move && score_next[15:3] != oScore[15:3] && speed_q < COORD_W'(MAX_SPEED))
            speed_q <= speed_q + 1'b1;
    end
    assign speed = speed_q;
`else
    assign speed = COORD_W'(SPEED);
`endif

    // Free-running in every state so player timing seeds the gap heights
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) lfsr <= LFSR_SEED;
        else         lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q   <= ST_IDLE;
            oScore    <= '0;
            oPipe_pix <= 1'b0;
            oBird_pix <= 1'b0;
        end else begin
            oPipe_pix <= |hit_v;
            oBird_pix <= bird_hit;
            case (state_q)
                ST_IDLE: if (iStart) begin
                    state_q <= ST_RUN;
                    oScore  <= '0;
                end
                ST_RUN: begin
                    if (dying)     state_q <= ST_DEAD;
                    else if (move) oScore  <= score_next;
                end
                ST_DEAD: if (iStart) state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign oState = state_q;

endmodule

// File: tb/tb_flappy_obstacle_engine.sv
// Randomised scoreboard bench for flappy_obstacle_engine against a game-rule model.
module tb_flappy_obstacle_engine;

    localparam int NP = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, frame = 1'b0;
    logic [10:0] pix_x = '0, pix_y = '0, bird_y = '0;
    logic        pipe_pix, bird_pix;
    logic [1:0]  state;
    logic [15:0] score;

    always #5 clk = ~clk;

    flappy_obstacle_engine dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iStart(start), .iFrame(frame),
        .iPix_x(pix_x), .iPix_y(pix_y), .iBird_y(bird_y),
        .oPipe_pix(pipe_pix), .oBird_pix(bird_pix), .oState(state), .oScore(score)
    );

    typedef struct packed {
        logic        pipe;
        logic        bird;
        logic [1:0]  st;
        logic [15:0] sc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0, n_bad = 0;

    // Game-level model: pipe positions, gaps, phase, score, speed, random source
    int          mx[NP], mg[NP];
    int          mstate, mscore, mspeed;
    bit          mpipe, mbird;
    logic [15:0] mlfsr;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    task automatic pipes_home();
        for (int i = 0; i < NP; i++) begin
            mx[i] = 320 + 200 * i;
            mg[i] = 40 + 32 * i;
        end
    endtask

    task automatic model_step(input bit rst_v, input bit st, input bit fr,
                              input int px, input int py, input int by);
        bit np, nb, dead_now;
        int cnt, ns, nx;
        exp_t e;
        if (!rst_v) begin
            pipes_home();
            mstate = 0; mscore = 0; mspeed = 5;
            mpipe = 0; mbird = 0; mlfsr = 16'hACE1;
        end else begin
            np = 0;
            for (int i = 0; i < NP; i++)
                if (px >= mx[i] && px < mx[i] + 80 && (py < mg[i] || py >= mg[i] + 100)) np = 1;
            nb = (px >= 100 && px < 120 && py >= by && py < by + 20);
            dead_now = (mstate == 1) && ((mpipe && mbird) || (fr && by >= 460));
            case (mstate)
                0: if (st) begin mstate = 1; mscore = 0; mspeed = 5; end
                1: if (dead_now) mstate = 2;
                   else if (fr) begin
                       cnt = 0;
                       for (int i = 0; i < NP; i++) begin
                           if (mx[i] < mspeed) begin
                               nx = mx[i] + NP * 200 - mspeed;
                               mg[i] = 40 + int'(mlfsr[7:0]);
                           end else nx = mx[i] - mspeed;
                           if (mx[i] + 80 >= 100 && nx + 80 < 100) cnt++;
                           mx[i] = nx;
                       end
                       ns = (mscore + cnt > 65535) ? 65535 : mscore + cnt;
`ifdef FLAPPY_SPEEDUP_EN
                       if (ns / 8 != mscore / 8 && mspeed < 12) mspeed++;
`endif
                       mscore = ns;
                   end
                default: if (st) begin mstate = 0; pipes_home(); end
            endcase
            mpipe = np; mbird = nb;
            mlfsr = lfsr_step(mlfsr);
        end
        e.pipe = mpipe; e.bird = mbird; e.st = 2'(mstate); e.sc = 16'(mscore);
        q.push_back(e);
    endtask

    task automatic cyc(input bit rst_v, input bit st, input bit fr,
                       input int px, input int py, input int by);
        @(negedge clk);
        rst_n = rst_v; start = st; frame = fr;
        pix_x = 11'(px); pix_y = 11'(py); bird_y = 11'(by);
        model_step(rst_v, st, fr, px, py, by);
    endtask

    function automatic void chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endfunction

    // Monitor: outputs are registered, so every post-edge sample is a response
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pipe_pix", int'(pipe_pix), int'(e.pipe));
            chk("bird_pix", int'(bird_pix), int'(e.bird));
            chk("state",    int'(state),    int'(e.st));
            chk("score",    int'(score),    int'(e.sc));
        end
    end

    function automatic int safe_x();
        int r;
        r = int'($urandom_range(0, 900));
        if (r >= 100 && r < 120) r += 20;
        return r;
    endfunction

    task automatic run_frames(input int n, input int by);
        for (int f = 0; f < n; f++) begin
            cyc(1, 0, 0, safe_x(), int'($urandom_range(0, 479)), by);
            cyc(1, 0, 1, safe_x(), int'($urandom_range(0, 479)), by);
        end
    endtask

    initial begin
        int guard;
        // reset and idle
        repeat (3) cyc(0, 0, 0, 0, 0, 200);
        repeat (6) cyc(1, 0, int'($urandom_range(0, 1)), int'($urandom_range(0, 900)),
                       int'($urandom_range(0, 479)), 200);
        cyc(1, 1, 0, 315, 10, 200);
        // long safe run: scrolling, wraps, scoring, no collisions possible
        for (int f = 0; f < 420; f++) begin
            cyc(1, int'($urandom_range(0, 9) == 0), 0, safe_x(), int'($urandom_range(0, 479)),
                int'($urandom_range(0, 439)));
            cyc(1, 0, 1, safe_x(), int'($urandom_range(0, 479)), int'($urandom_range(0, 439)));
        end
        // ground death, restart to IDLE, then RUN again with score cleared
        cyc(1, 0, 1, 500, 10, 460);
        run_frames(3, 200);
        cyc(1, 1, 0, 700, 10, 200);
        repeat (3) cyc(1, 0, 0, int'($urandom_range(0, 1000)), int'($urandom_range(0, 479)), 200);
        cyc(1, 1, 0, 320, 10, 200);
        // pipe 0 over the bird column, then collision coinciding with a frame tick
        run_frames(50, 200);
        cyc(1, 0, 0, 105, 5, 0);
        cyc(1, 0, 1, 700, 300, 0);
        run_frames(4, 0);
        cyc(1, 1, 0, 0, 0, 200);
        cyc(1, 0, 0, 0, 0, 200);
        cyc(1, 1, 0, 0, 0, 200);
        // chaotic play: random pixels everywhere, random starts and ground hits
        for (int c = 0; c < 3000; c++)
            cyc(1, int'($urandom_range(0, 29) == 0), int'(c % 3 == 2),
                int'($urandom_range(0, 1023)), int'($urandom_range(0, 511)),
                int'($urandom_range(0, 479)));
        // async reset in the middle of a game
        cyc(1, 1, 0, 0, 0, 200);
        run_frames(5, 200);
        cyc(0, 0, 1, 330, 10, 200);
        cyc(0, 1, 0, 330, 10, 200);
        cyc(1, 0, 0, 330, 10, 200);
        run_frames(10, 200);
        cyc(1, 1, 0, 330, 10, 200);
        run_frames(10, 200);
        cyc(1, 0, 0, 0, 0, 200);
        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            #2;
            guard++;
        end
        n_cmp++;
        if (q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d responses outstanding, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
